// File: rtl/wb_regfile_stage_pkg.sv
// Shared writeback / register-file definitions.
// Also consumed by the ID, EX and forwarding stages.
package wb_regfile_stage_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

    // Writeback value selection: load data or ALU result.
    function automatic data_t wb_select(
        input logic  mem_to_reg,
        input data_t mem_data,
        input data_t alu_data
    );
        data_t sel;
        if (mem_to_reg) begin
            sel = mem_data;
        end else begin
            sel = alu_data;
        end
        return sel;
    endfunction

endpackage

// File: rtl/wb_regfile_stage_if.sv
// MEM/WB pipeline bundle into the writeback stage.
// master = MEM/WB buffer, slave = writeback stage.
interface wb_regfile_stage_if;
    import wb_regfile_stage_pkg::*;

    logic     RegWrite_in;
    logic     MemtoReg_in;
    data_t    mem_read_data_in;
    data_t    alu_result_in;
    reg_idx_t write_reg_in;

    modport master (
        output RegWrite_in,
        output MemtoReg_in,
        output mem_read_data_in,
        output alu_result_in,
        output write_reg_in
    );

    modport slave (
        input RegWrite_in,
        input MemtoReg_in,
        input mem_read_data_in,
        input alu_result_in,
        input write_reg_in
    );

endinterface

// File: rtl/wb_regfile_stage_array.sv
// Integer register storage: 1 write port, 2 async reads.
// Entry 0 is hardwired to zero.
module wb_regfile_array
    import wb_regfile_stage_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     we,
    input  reg_idx_t waddr,
    input  data_t    wdata,
    input  reg_idx_t raddr_a,
    input  reg_idx_t raddr_b,
    output data_t    rdata_a,
    output data_t    rdata_b
);

    data_t regs_q [NUM_REGS];
    data_t regs_d [NUM_REGS];

    // Next-state: one entry updated on write, r0 pinned to zero.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we && (waddr != ZERO_REG)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    // Storage flops, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Asynchronous read ports.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (raddr_a != ZERO_REG) begin
            rdata_a = regs_q[raddr_a];
        end
        if (raddr_b != ZERO_REG) begin
            rdata_b = regs_q[raddr_b];
        end
    end

endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: data mux, regfile commit, ID read
// bypass, EX forwarding tap and committed-write counter.
module wb_regfile_stage
    import wb_regfile_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    wb_regfile_stage_if.slave  bus,
    input  reg_idx_t           rs_addr,
    input  reg_idx_t           rt_addr,
    output data_t              rs_data,
    output data_t              rt_data,
    output logic               wb_fwd_en,
    output reg_idx_t           wb_fwd_reg,
    output data_t              wb_fwd_data,
    output logic [CNT_W-1:0]   wb_count
);

    data_t            wb_data;
    logic             commit;
    data_t            arr_rs;
    data_t            arr_rt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Writeback mux and commit qualification (held off in reset).
    always_comb begin
        wb_data = wb_select(bus.MemtoReg_in,
                            bus.mem_read_data_in,
                            bus.alu_result_in);
        commit  = bus.RegWrite_in
               && (bus.write_reg_in != ZERO_REG)
               && reset;
    end

    wb_regfile_array u_array (
        .clk     (clk),
        .reset   (reset),
        .we      (commit),
        .waddr   (bus.write_reg_in),
        .wdata   (wb_data),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .rdata_a (arr_rs),
        .rdata_b (arr_rt)
    );

    // Write-first bypass so ID sees this cycle's result.
    always_comb begin
        rs_data = arr_rs;
        rt_data = arr_rt;
        unique case (1'b1)
            (rs_addr == ZERO_REG):
                rs_data = '0;
            (commit && (rs_addr == bus.write_reg_in)):
                rs_data = wb_data;
            default:
                rs_data = arr_rs;
        endcase
        unique case (1'b1)
            (rt_addr == ZERO_REG):
                rt_data = '0;
            (commit && (rt_addr == bus.write_reg_in)):
                rt_data = wb_data;
            default:
                rt_data = arr_rt;
        endcase
    end

    // Forwarding tap; consumers gate reg/data on the enable.
    always_comb begin
        wb_fwd_en   = commit;
        wb_fwd_reg  = bus.write_reg_in;
        wb_fwd_data = wb_data;
    end

    // Committed-write count, wraps naturally.
    always_comb begin
        count_d = count_q;
        if (commit) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign wb_count = count_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Bench for wb_regfile_stage: reference model + per-cycle
// compare, directed vectors with literal expectations.
module tb_wb_regfile_stage;
    import wb_regfile_stage_pkg::*;

    logic     clk;
    logic     reset;
    reg_idx_t rs_addr;
    reg_idx_t rt_addr;

    data_t       rs_data, rt_data, fwd_data;
    logic        fwd_en;
    reg_idx_t    fwd_reg;
    logic [31:0] count;

    data_t       rs_data4, rt_data4, fwd_data4;
    logic        fwd_en4;
    reg_idx_t    fwd_reg4;
    logic [3:0]  count4;

    int total = 0;
    int bad   = 0;

    wb_regfile_stage_if bus ();

    wb_regfile_stage #(.CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .wb_fwd_en   (fwd_en),
        .wb_fwd_reg  (fwd_reg),
        .wb_fwd_data (fwd_data),
        .wb_count    (count)
    );

    wb_regfile_stage #(.CNT_W(4)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data4),
        .rt_data     (rt_data4),
        .wb_fwd_en   (fwd_en4),
        .wb_fwd_reg  (fwd_reg4),
        .wb_fwd_data (fwd_data4),
        .wb_count    (count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    function automatic logic [31:0] m_wbd();
        return bus.MemtoReg_in ? bus.mem_read_data_in
                               : bus.alu_result_in;
    endfunction

    function automatic logic m_commit();
        return reset === 1'b1 && bus.RegWrite_in === 1'b1
            && bus.write_reg_in != 5'd0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (reset !== 1'b1 || a == 5'd0) return 32'd0;
        if (m_commit() && a == bus.write_reg_in) return m_wbd();
        return m_regs[a];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_cnt = 32'd0;
        end else if (m_commit()) begin
            m_regs[bus.write_reg_in] = m_wbd();
            m_cnt = m_cnt + 32'd1;
        end
    end

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("m_rs", rs_data, m_read(rs_addr));
        check("m_rt", rt_data, m_read(rt_addr));
        check("m_fen", {31'd0, fwd_en}, {31'd0, m_commit()});
        check("m_freg", {27'd0, fwd_reg}, {27'd0, bus.write_reg_in});
        check("m_fdat", fwd_data, m_wbd());
        check("m_cnt", count, m_cnt);
        check("m_cnt4", {28'd0, count4}, {28'd0, m_cnt[3:0]});
        check("m_rs4", rs_data4, m_read(rs_addr));
        check("m_rt4", rt_data4, m_read(rt_addr));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic m2r,
                         input logic [31:0] mem,
                         input logic [31:0] alu,
                         input logic [4:0] wr);
        bus.RegWrite_in      = rw;
        bus.MemtoReg_in      = m2r;
        bus.mem_read_data_in = mem;
        bus.alu_result_in    = alu;
        bus.write_reg_in     = wr;
    endtask

    initial begin
        reset   = 1'b0;
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        step();
        step();
        reset = 1'b1;
        #1;
        check("rst_cnt", count, 32'd0);
        check("rst_rs", rs_data, 32'd0);

        // Write r5 then reset mid-run.
        drive(1'b1, 1'b0, 32'd0, 32'h1234, 5'd5);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        rs_addr = 5'd5;
        #1;
        check("r5_rd", rs_data, 32'h1234);
        check("r5_cnt", count, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_rs", rs_data, 32'd0);
        check("mid_rst_cnt", count, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 32'h99, 5'd5);
        #1;
        check("rst_fen", {31'd0, fwd_en}, 32'd0);
        check("rst_fdat", fwd_data, 32'h99);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        reset = 1'b1;
        #1;
        check("rst_noc", rs_data, 32'd0);

        // ALU writeback, unselected leg undriven.
        drive(1'b1, 1'b0, 32'hx, 32'hDEADBEEF, 5'd8);
        #1;
        check("alu_fdat", fwd_data, 32'hDEADBEEF);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        rs_addr = 5'd8;
        #1;
        check("alu_rd", rs_data, 32'hDEADBEEF);
        check("alu_cnt", count, 32'd1);

        // Memory writeback with double bypass.
        drive(1'b1, 1'b1, 32'h0000CAFE, 32'h1, 5'd3);
        rs_addr = 5'd3;
        rt_addr = 5'd3;
        #1;
        check("byp_rs", rs_data, 32'h0000CAFE);
        check("byp_rt", rt_data, 32'h0000CAFE);
        check("byp_fen", {31'd0, fwd_en}, 32'd1);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        #1;
        check("mem_rs", rs_data, 32'h0000CAFE);
        check("mem_rt", rt_data, 32'h0000CAFE);
        check("mem_cnt", count, 32'd2);

        // Write to r0 is dropped.
        drive(1'b1, 1'b0, 32'd0, 32'hFFFFFFFF, 5'd0);
        rs_addr = 5'd0;
        #1;
        check("r0_rs", rs_data, 32'd0);
        check("r0_fen", {31'd0, fwd_en}, 32'd0);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        #1;
        check("r0_cnt", count, 32'd2);

        // RegWrite low ignores data.
        drive(1'b1, 1'b0, 32'd0, 32'h77, 5'd9);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'h55, 5'd9);
        rs_addr = 5'd9;
        #1;
        check("nw_rs", rs_data, 32'h77);
        check("nw_fen", {31'd0, fwd_en}, 32'd0);
        step();
        check("nw_rs2", rs_data, 32'h77);
        check("nw_cnt", count, 32'd3);

        // Independent rt bypass.
        drive(1'b1, 1'b0, 32'd0, 32'hA, 5'd10);
        rs_addr = 5'd9;
        rt_addr = 5'd10;
        #1;
        check("rt_byp_rs", rs_data, 32'h77);
        check("rt_byp_rt", rt_data, 32'hA);
        step();

        // Counter wrap on the 4-bit build.
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i[0], 32'h100 + i, 32'h200 + i,
                  5'(1 + (i % 31)));
            rs_addr = 5'(1 + (i % 31));
            rt_addr = 5'(i % 4);
            step();
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        #1;
        check("wrap_cnt4", {28'd0, count4}, 32'd0);
        check("wrap_cnt", count, 32'd16);
        rs_addr = 5'd2;
        rt_addr = 5'd3;
        #1;
        check("wrap_r2", rs_data, 32'h101);
        check("wrap_r3", rt_data, 32'h202);

        // Sweep reads across the file.
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
